octree_lookup: RTL and testbench
================================

Name: octree_lookup

Overview:
- Traversal stage directly upstream of the octree ROM. It takes a voxel coordinate query and walks the octree from the root, one level per fetch.
- Drives one ROM read port (address, read-enable) and consumes that port's registered data a cycle later.
- Returns the leaf material, the depth reached and an error flag to the downstream shading stage over a valid/ready handshake.
- One lookup is in flight at a time; a second instance can own the other ROM port.

Parameters:
- COORD_WIDTH, 10, bits per axis coordinate; also the maximum tree depth.
- ADDRESS_WIDTH, 32, ROM address width.
- DATA_WIDTH, 32, ROM word width; must be 32.
- ROM_DEPTH, 4306, number of valid ROM words; addresses >= ROM_DEPTH are illegal.
- ROOT_ADDR, 0, address of the root node.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  query valid
- req_ready  out  1  block can accept a query
- req_x, req_y, req_z  in  COORD_WIDTH each  voxel coordinate
- rom_addr  out  ADDRESS_WIDTH  ROM read address
- rom_ren  out  1  ROM read enable
- rom_dout  in  DATA_WIDTH  ROM data, valid the cycle after rom_ren
- resp_valid  out  1  result valid
- resp_ready  in  1  downstream accepts result
- resp_leaf  out  8  leaf material byte
- resp_depth  out  $clog2(COORD_WIDTH+1)  level of the terminating node; root = 0
- resp_err  out  1  lookup failed

Behaviour:
- Node word format:
  - bit31 = 1: leaf; bits[7:0] = material.
  - bit31 = 0: internal; bits[30:0] = child base address. Child for octant o is at base+o.
- Octant at depth d: o = {x[b], y[b], z[b]}, where b = COORD_WIDTH-1-d. x is the MSB of o.
- States: IDLE, ISSUE, DECODE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch the coordinates, set depth = 0, set addr = ROOT_ADDR, go to ISSUE.
- ISSUE:
  - rom_ren = 1, rom_addr = addr.
  - Go to DECODE.
- DECODE (rom_dout is valid here):
  - Leaf: capture material and depth, clear err, go to RESP.
  - Internal with depth == COORD_WIDTH: err = 1, leaf = 0, go to RESP.
  - Internal with base+7 >= ROM_DEPTH: err = 1, leaf = 0, go to RESP.
  - Otherwise: addr = base+o (o taken at the current depth), depth += 1, go to ISSUE.
  - Compare in ADDRESS_WIDTH+1 bits so that base+7 cannot wrap.
- RESP:
  - resp_valid = 1.
  - resp_leaf, resp_depth and resp_err are held stable until resp_ready.
  - On resp_ready: go to IDLE.
- rom_ren is 0 in every state except ISSUE; rom_addr holds its last value.
- req_ready is 1 only in IDLE. No new query is accepted in the RESP cycle.
- Latency: a leaf at depth d gives resp_valid exactly 2(d+1)+1 cycles after the accepting edge. Root leaf = 3 cycles.
- Reset values:
  - state = IDLE, req_ready = 1 (combinational from state).
  - rom_ren = 0, rom_addr = 0.
  - resp_valid = 0, resp_leaf = 0, resp_depth = 0, resp_err = 0.
- Reset mid-lookup aborts the lookup: no response is produced and the next cycle is IDLE.
- resp_ready held high in RESP: one-cycle response, then IDLE.
- Holding req_valid while busy has no effect; the query is taken in the next IDLE cycle.

Optional Feature:
- Macro OCTREE_LOOKUP_STATS_EN.
- Defined:
  - Adds output resp_fetches (8 bits): number of ROM reads for this lookup, saturating at 255, valid with resp_valid.
  - Adds output total_fetches (32 bits): free-running count of rom_ren cycles, cleared by rst, wraps at 2^32.
- Undefined: neither port nor any counter logic exists. Traversal behaviour is identical either way.

Decomposition:
- Package octree_pkg holds:
  - node-format constants: LEAF_BIT = 31, MAT_MSB = 7, CHILD_MSB = 30;
  - the state enum;
  - function octant_of(x, y, z, depth).
- One sub-module, octree_node_decode (combinational): word + depth + coords in; is_leaf, material, next_addr, err out.

Test Plan:
- Root leaf: ROM[0] = 0x800000AB, query (0,0,0) -> resp_leaf 0xAB, depth 0, err 0, resp_valid at cycle 3, exactly one rom_ren pulse.
- One level: ROM[0] = 0x00000001, ROM[6] = 0x800000CD, query (0x200, 0, 0x200) (octant 5) -> rom_addr sequence 0, 6; leaf 0xCD, depth 1, resp_valid at cycle 5.
- Bad child: ROM[0] = 0x000010D0 (base 4304, base+7 >= 4306) -> err 1, leaf 0, depth 0.
- Depth exhaustion: chain of internal nodes through depth 10, all in range -> err 1, depth 10, 11 fetches.
- Backpressure and reset: resp_ready low for 4 cycles -> outputs stable, req_ready 0. Then assert rst in the ISSUE of a second query -> IDLE next cycle, no resp_valid, rom_ren 0.

Source files
------------

// File: rtl/octree_pkg.sv
// Shared definitions for the octree traversal stage: node word layout,
// traversal states and the per-level octant selection helper.
package octree_pkg;

  localparam int LEAF_BIT  = 31;
  localparam int MAT_MSB   = 7;
  localparam int CHILD_MSB = 30;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DECODE = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Octant {x,y,z} taken from bit (coord_width-1-depth); coordinates zero-extended.
  function automatic logic [2:0] octant_of(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic [31:0] z,
                                           input int unsigned depth,
                                           input int unsigned coord_width = 10);
    int unsigned b;
    logic [31:0] xs, ys, zs;
    if (depth >= coord_width) begin
      return 3'd0;
    end
    b  = coord_width - 1 - depth;
    xs = x >> b;
    ys = y >> b;
    zs = z >> b;
    return {xs[0], ys[0], zs[0]};
  endfunction

endpackage

// File: rtl/octree_node_decode.sv
// Combinational decode of one fetched node word into leaf/material, the
// next child address and the termination error (depth or range exhausted).
module octree_node_decode
  import octree_pkg::*;
#(
  parameter int COORD_WIDTH   = 10,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ROM_DEPTH     = 4306,
  parameter int DEPTH_W       = $clog2(COORD_WIDTH + 1)
) (
  input  logic [DATA_WIDTH-1:0]    word_i,
  input  logic [DEPTH_W-1:0]       depth_i,
  input  logic [COORD_WIDTH-1:0]   x_i,
  input  logic [COORD_WIDTH-1:0]   y_i,
  input  logic [COORD_WIDTH-1:0]   z_i,
  output logic                     is_leaf_o,
  output logic [7:0]               material_o,
  output logic [ADDRESS_WIDTH-1:0] next_addr_o,
  output logic                     err_o
);

  localparam int AW1 = ADDRESS_WIDTH + 1;

  logic [2:0]     octant;
  logic [AW1-1:0] base_ext;
  logic [AW1-1:0] last_child;
  logic           depth_full;
  logic           out_of_range;

  always_comb begin
    octant       = octant_of(32'(x_i), 32'(y_i), 32'(z_i), 32'(depth_i), COORD_WIDTH);
    // One extra bit keeps base+7 from wrapping past the range check.
    base_ext     = AW1'(word_i[CHILD_MSB:0]);
    last_child   = base_ext + AW1'(7);
    out_of_range = (last_child >= AW1'(ROM_DEPTH));
    depth_full   = (depth_i == DEPTH_W'(COORD_WIDTH));
    is_leaf_o    = word_i[LEAF_BIT];
    material_o   = word_i[MAT_MSB:0];
    next_addr_o  = ADDRESS_WIDTH'(base_ext + AW1'(octant));
    err_o        = !word_i[LEAF_BIT] && (depth_full || out_of_range);
  end

endmodule

// File: rtl/octree_lookup.sv
// Octree traversal stage: walks from the root one ROM fetch per level and
// returns leaf/depth/err. OCTREE_LOOKUP_STATS_EN adds fetch counters.
module octree_lookup
  import octree_pkg::*;
#(
  parameter int          COORD_WIDTH   = 10,
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter int          ROM_DEPTH     = 4306,
  parameter int unsigned ROOT_ADDR     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [COORD_WIDTH-1:0]           req_x,
  input  logic [COORD_WIDTH-1:0]           req_y,
  input  logic [COORD_WIDTH-1:0]           req_z,
  output logic [ADDRESS_WIDTH-1:0]         rom_addr,
  output logic                             rom_ren,
  input  logic [DATA_WIDTH-1:0]            rom_dout,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [7:0]                       resp_leaf,
  output logic [$clog2(COORD_WIDTH+1)-1:0] resp_depth,
  output logic                             resp_err
`ifdef OCTREE_LOOKUP_STATS_EN
  ,
  output logic [7:0]                       resp_fetches,
  output logic [31:0]                      total_fetches
`endif
);

  localparam int DEPTH_W = $clog2(COORD_WIDTH + 1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DEPTH_W-1:0]       depth_q, depth_d;
  logic [COORD_WIDTH-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic [7:0]               leaf_q, leaf_d;
  logic [DEPTH_W-1:0]       rdepth_q, rdepth_d;
  logic                     err_q, err_d;

  logic                     dec_leaf;
  logic [7:0]               dec_material;
  logic [ADDRESS_WIDTH-1:0] dec_next_addr;
  logic                     dec_err;

  octree_node_decode #(
    .COORD_WIDTH  (COORD_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .ROM_DEPTH    (ROM_DEPTH),
    .DEPTH_W      (DEPTH_W)
  ) u_decode (
    .word_i     (rom_dout),
    .depth_i    (depth_q),
    .x_i        (x_q),
    .y_i        (y_q),
    .z_i        (z_q),
    .is_leaf_o  (dec_leaf),
    .material_o (dec_material),
    .next_addr_o(dec_next_addr),
    .err_o      (dec_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      depth_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      leaf_q   <= '0;
      rdepth_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      depth_q  <= depth_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      leaf_q   <= leaf_d;
      rdepth_q <= rdepth_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    depth_d    = depth_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    leaf_d     = leaf_q;
    rdepth_d   = rdepth_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    rom_ren    = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          x_d     = req_x;
          y_d     = req_y;
          z_d     = req_z;
          depth_d = '0;
          addr_d  = ADDRESS_WIDTH'(ROOT_ADDR);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rom_ren = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_leaf) begin
          leaf_d   = dec_material;
          rdepth_d = depth_q;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (dec_err) begin
          leaf_d   = 8'h00;
          rdepth_d = depth_q;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          addr_d   = dec_next_addr;
          depth_d  = depth_q + DEPTH_W'(1);
          state_d  = S_ISSUE;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr   = addr_q;
  assign resp_leaf  = leaf_q;
  assign resp_depth = rdepth_q;
  assign resp_err   = err_q;

`ifdef OCTREE_LOOKUP_STATS_EN
  logic [7:0]  fetch_q;
  logic [31:0] total_fetches_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q         <= '0;
      total_fetches_q <= '0;
    end else begin
      if (rom_ren) begin
        total_fetches_q <= total_fetches_q + 32'd1;
      end
      if (state_q == S_IDLE && req_valid) begin
        fetch_q <= '0;
      end else if (rom_ren && fetch_q != 8'hFF) begin
        fetch_q <= fetch_q + 8'd1;
      end
    end
  end

  assign resp_fetches  = fetch_q;
  assign total_fetches = total_fetches_q;
`endif

endmodule

// File: tb/tb_octree_lookup.sv
// Directed-vector bench for octree_lookup with a registered-read ROM model.
module tb_octree_lookup;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_x, req_y, req_z;
  logic [31:0] rom_addr;
  logic        rom_ren;
  logic [31:0] rom_dout;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_leaf;
  logic [3:0]  resp_depth;
  logic        resp_err;
`ifdef OCTREE_LOOKUP_STATS_EN
  logic [7:0]  resp_fetches;
  logic [31:0] total_fetches;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] rom_mem [0:8191];
  logic [31:0] addr_log[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_ren) rom_dout <= rom_mem[rom_addr[12:0]];
  end

  octree_lookup dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_z     (req_z),
    .rom_addr  (rom_addr),
    .rom_ren   (rom_ren),
    .rom_dout  (rom_dout),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_leaf (resp_leaf),
    .resp_depth(resp_depth),
    .resp_err  (resp_err)
`ifdef OCTREE_LOOKUP_STATS_EN
    ,
    .resp_fetches (resp_fetches),
    .total_fetches(total_fetches)
`endif
  );

  // Issues one query from IDLE and stops at the first cycle resp_valid is seen.
  task automatic do_query(input logic [9:0] x, input logic [9:0] y, input logic [9:0] z,
                          output int lat, output int nren, output logic ok);
    addr_log.delete();
    req_x = x; req_y = y; req_z = z;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat  = 1;
    nren = 0;
    while (!resp_valid && lat < 200) begin
      if (rom_ren) begin
        nren++;
        addr_log.push_back(rom_addr);
      end
      @(posedge clk); #1;
      lat++;
    end
    ok = resp_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    req_x = '0; req_y = '0; req_z = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b1 || rom_ren !== 1'b0 || rom_addr !== 32'd0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready=%b ren=%b addr=%0h valid=%b, required 1 0 0 0",
               req_ready, rom_ren, rom_addr, resp_valid);
    end
    vectors++;
    if (resp_leaf !== 8'h00 || resp_depth !== 4'd0 || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_resp: leaf=%0h depth=%0d err=%b, required 0 0 0",
               resp_leaf, resp_depth, resp_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: ready=%b valid=%b", req_ready, resp_valid);
  endtask

  task automatic test_root_leaf;
    int lat, nren; logic ok;
    rom_mem[0] = 32'h800000AB;
    do_query(10'd0, 10'd0, 10'd0, lat, nren, ok);
    vectors++;
    if (!ok || lat != 3 || nren != 1) begin
      miscompares++;
      $display("FAIL root_timing: ok=%b lat=%0d ren=%0d, required 1 3 1", ok, lat, nren);
    end
    vectors++;
    if (resp_leaf !== 8'hAB || resp_depth !== 4'd0 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL root_result: leaf=%0h depth=%0d err=%b ready=%b, required ab 0 0 0",
               resp_leaf, resp_depth, resp_err, req_ready);
    end
    $display("root_leaf: lat=%0d leaf=%0h depth=%0d err=%b", lat, resp_leaf, resp_depth, resp_err);
    @(posedge clk); #1;
  endtask

  task automatic test_one_level;
    int lat, nren; logic ok;
    rom_mem[0] = 32'h00000001;
    rom_mem[6] = 32'h800000CD;
    do_query(10'h200, 10'h000, 10'h200, lat, nren, ok);
    vectors++;
    if (!ok || lat != 5 || nren != 2) begin
      miscompares++;
      $display("FAIL one_level_timing: ok=%b lat=%0d ren=%0d, required 1 5 2", ok, lat, nren);
    end
    vectors++;
    if (addr_log.size() != 2 || addr_log[0] !== 32'd0 || addr_log[1] !== 32'd6) begin
      miscompares++;
      $display("FAIL one_level_addrs: n=%0d first=%0h second=%0h, required 2 0 6",
               addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 32'hX,
               (addr_log.size() > 1) ? addr_log[1] : 32'hX);
    end
    vectors++;
    if (resp_leaf !== 8'hCD || resp_depth !== 4'd1 || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL one_level_result: leaf=%0h depth=%0d err=%b, required cd 1 0",
               resp_leaf, resp_depth, resp_err);
    end
    $display("one_level: lat=%0d leaf=%0h depth=%0d err=%b", lat, resp_leaf, resp_depth, resp_err);
    @(posedge clk); #1;
  endtask

  task automatic test_bad_child;
    int lat, nren; logic ok;
    rom_mem[0] = 32'h000010D0;  // base 4304
    do_query(10'd0, 10'd0, 10'd0, lat, nren, ok);
    vectors++;
    if (!ok || lat != 3 || nren != 1 || resp_leaf !== 8'h00 || resp_depth !== 4'd0 || resp_err !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_child: ok=%b lat=%0d ren=%0d leaf=%0h depth=%0d err=%b, required 1 3 1 0 0 1",
               ok, lat, nren, resp_leaf, resp_depth, resp_err);
    end
    $display("bad_child: leaf=%0h depth=%0d err=%b", resp_leaf, resp_depth, resp_err);
    @(posedge clk); #1;
  endtask

  task automatic test_range_boundary;
    int lat, nren; logic ok;
    rom_mem[0]    = 32'h000010CA;  // base 4298: last child 4305, still legal
    rom_mem[4305] = 32'h80000077;
    do_query(10'h3FF, 10'h3FF, 10'h3FF, lat, nren, ok);
    vectors++;
    if (!ok || lat != 5 || resp_leaf !== 8'h77 || resp_depth !== 4'd1 || resp_err !== 1'b0
        || addr_log.size() != 2 || addr_log[addr_log.size()-1] !== 32'd4305) begin
      miscompares++;
      $display("FAIL range_edge_ok: ok=%b lat=%0d leaf=%0h depth=%0d err=%b, required 1 5 77 1 0",
               ok, lat, resp_leaf, resp_depth, resp_err);
    end
    $display("range_edge_ok: leaf=%0h depth=%0d err=%b", resp_leaf, resp_depth, resp_err);
    @(posedge clk); #1;
    rom_mem[0] = 32'h000010CB;  // base 4299: last child 4306, illegal
    do_query(10'h3FF, 10'h3FF, 10'h3FF, lat, nren, ok);
    vectors++;
    if (!ok || lat != 3 || resp_leaf !== 8'h00 || resp_depth !== 4'd0 || resp_err !== 1'b1) begin
      miscompares++;
      $display("FAIL range_edge_bad: ok=%b lat=%0d leaf=%0h depth=%0d err=%b, required 1 3 0 0 1",
               ok, lat, resp_leaf, resp_depth, resp_err);
    end
    $display("range_edge_bad: leaf=%0h depth=%0d err=%b", resp_leaf, resp_depth, resp_err);
    @(posedge clk); #1;
  endtask

  task automatic test_depth_exhaustion;
    int lat, nren; logic ok;
    for (int d = 0; d <= 10; d++) rom_mem[8*d] = 32'(8*(d+1));
    do_query(10'd0, 10'd0, 10'd0, lat, nren, ok);
    vectors++;
    if (!ok || nren != 11 || lat != 23) begin
      miscompares++;
      $display("FAIL depth_timing: ok=%b ren=%0d lat=%0d, required 1 11 23", ok, nren, lat);
    end
    vectors++;
    if (addr_log.size() != 11 || addr_log[addr_log.size()-1] !== 32'd80) begin
      miscompares++;
      $display("FAIL depth_addrs: n=%0d, required 11 ending at 80", addr_log.size());
    end
    vectors++;
    if (resp_leaf !== 8'h00 || resp_depth !== 4'd10 || resp_err !== 1'b1) begin
      miscompares++;
      $display("FAIL depth_result: leaf=%0h depth=%0d err=%b, required 0 10 1",
               resp_leaf, resp_depth, resp_err);
    end
    $display("depth_exhaustion: fetches=%0d depth=%0d err=%b", nren, resp_depth, resp_err);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure_reset;
    int lat, nren; logic ok; logic stable; logic quiet;
    rom_mem[0] = 32'h800000AB;
    resp_ready = 1'b0;
    do_query(10'd0, 10'd0, 10'd0, lat, nren, ok);
    vectors++;
    if (!ok || lat != 3) begin
      miscompares++;
      $display("FAIL bp_arrive: ok=%b lat=%0d, required 1 3", ok, lat);
    end
    // A pending query held during backpressure must wait for IDLE.
    req_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_leaf !== 8'hAB || resp_depth !== 4'd0
          || resp_err !== 1'b0 || req_ready !== 1'b0 || rom_ren !== 1'b0) stable = 1'b0;
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL bp_hold: valid=%b leaf=%0h ready=%b ren=%b, required 1 ab 0 0",
               resp_valid, resp_leaf, req_ready, rom_ren);
    end
    $display("backpressure: valid=%b leaf=%0h ready=%b", resp_valid, resp_leaf, req_ready);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (rom_ren !== 1'b1 || rom_addr !== 32'd0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL held_query_issue: ren=%b addr=%0h ready=%b, required 1 0 0",
               rom_ren, rom_addr, req_ready);
    end
    rst = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || rom_ren !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: ready=%b ren=%b valid=%b, required 1 0 0",
               req_ready, rom_ren, resp_valid);
    end
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0 || rom_ren !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL reset_quiet: valid=%b ren=%b, required 0 0", resp_valid, rom_ren);
    end
    $display("reset_abort: ready=%b valid=%b ren=%b", req_ready, resp_valid, rom_ren);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom_mem[i] = 32'h0;
    test_reset();
    test_root_leaf();
    test_one_level();
    test_bad_child();
    test_range_boundary();
    test_depth_exhaustion();
    test_backpressure_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
